karatsuba_seq_ctrl_26bit: RTL and testbench



---
 rtl/karatsuba_seq_ctrl_26bit_if.sv | 42 ++++
 rtl/karatsuba_seq_ctrl_26bit.sv | 168 ++++++++++++++++
 tb/tb_karatsuba_seq_ctrl_26bit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/karatsuba_seq_ctrl_26bit_if.sv
// Handshake bundle between the Karatsuba controller, its operand
// producer/result consumer and the shared half-width multiplier.
interface karatsuba_seq_ctrl_26bit_if #(
  parameter int N = 26
);
  localparam int H = N / 2;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             mul_start;
  logic [H-1:0]     mul_a;
  logic [H-1:0]     mul_b;
  logic             mul_done;
  logic [2*H-2:0]   mul_prod;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-2:0]   result;
  logic             busy;
  logic             err;

  modport master (
    output in_valid, a_in, b_in,
    output mul_done, mul_prod,
    output out_ready,
    input  in_ready, mul_start,
    input  mul_a, mul_b,
    input  out_valid, result,
    input  busy, err
  );

  modport slave (
    input  in_valid, a_in, b_in,
    input  mul_done, mul_prod,
    input  out_ready,
    output in_ready, mul_start,
    output mul_a, mul_b,
    output out_valid, result,
    output busy, err
  );
endinterface

// File: rtl/karatsuba_seq_ctrl_26bit.sv
// Sequential Karatsuba controller: one shared HxH carry-less multiplier
// is issued low, middle and high partial products, then recombined.
module karatsuba_seq_ctrl_26bit #(
  parameter int N       = 26,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  karatsuba_seq_ctrl_26bit_if.slave    bus
);

  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;
  localparam int RW = 2 * N - 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      k;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [PW-1:0]   pl;
  logic [PW-1:0]   pm;
  logic [PW-1:0]   ph;

  logic            in_ready_q;
  logic            mul_start_q;
  logic [H-1:0]    mul_a_q;
  logic [H-1:0]    mul_b_q;
  logic            out_valid_q;
  logic [RW-1:0]   result_q;
  logic            busy_q;
  logic            err_q;

  function automatic logic [H-1:0] opnd(
    input logic [N-1:0] x,
    input logic [1:0]   kk
  );
    logic [H-1:0] r;
    unique case (1'b1)
      kk == 2'd0: r = x[H-1:0];
      kk == 2'd1: r = x[H-1:0] ^ x[N-1:H];
      default:    r = x[N-1:H];
    endcase
    return r;
  endfunction

  // Middle term is corrected by Pl^Ph before the H-bit-offset overlap.
  function automatic logic [RW-1:0] combine(
    input logic [PW-1:0] l,
    input logic [PW-1:0] m,
    input logic [PW-1:0] h
  );
    logic [PW-1:0] mid;
    logic [RW-1:0] el;
    logic [RW-1:0] em;
    logic [RW-1:0] eh;
    mid = l ^ m ^ h;
    el  = {{(RW-PW){1'b0}}, l};
    em  = {{(RW-PW){1'b0}}, mid};
    eh  = {{(RW-PW){1'b0}}, h};
    return el ^ (em << H) ^ (eh << N);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pl          <= '0;
      pm          <= '0;
      ph          <= '0;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q         <= bus.a_in;
            b_q         <= bus.b_in;
            k           <= 2'd0;
            cnt         <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            mul_start_q <= 1'b1;
            mul_a_q     <= opnd(bus.a_in, 2'd0);
            mul_b_q     <= opnd(bus.b_in, 2'd0);
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            unique case (1'b1)
              k == 2'd0: pl <= bus.mul_prod;
              k == 2'd1: pm <= bus.mul_prod;
              default:   ph <= bus.mul_prod;
            endcase
            if (k == 2'd2) begin
              result_q    <= combine(pl, pm, bus.mul_prod);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              k           <= k + 2'd1;
              cnt         <= '0;
              mul_start_q <= 1'b1;
              mul_a_q     <= opnd(a_q, k + 2'd1);
              mul_b_q     <= opnd(b_q, k + 2'd1);
              state       <= ISSUE;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            cnt        <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_karatsuba_seq_ctrl_26bit.sv
// Randomised bench: controller driven against a latency-configurable
// carry-less multiplier model; results compared to a direct clmul.
module tb_karatsuba_seq_ctrl_26bit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  karatsuba_seq_ctrl_26bit_if #(.N(26)) bus ();

  karatsuba_seq_ctrl_26bit #(
    .N(26),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          lat_cfg = 1;
  int          drop_at = -1;
  int          starts  = 0;
  logic        inject  = 1'b0;
  logic        mdl_pend = 1'b0;
  int          mdl_cnt = 0;
  logic [24:0] mdl_prod = '0;
  logic [25:0] op_log[$];

  function automatic logic [50:0] clmul(
    input logic [25:0] x,
    input logic [25:0] y
  );
    logic [50:0] r;
    r = '0;
    for (int i = 0; i < 26; i++)
      if (y[i]) r = r ^ ({25'b0, x} << i);
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // External half-width multiplier model, answering lat_cfg cycles after start
  always @(negedge clk) begin
    logic [50:0] p;
    bus.mul_done = 1'b0;
    if (inject) bus.mul_done = 1'b1;
    if (mdl_pend) begin
      mdl_cnt--;
      if (mdl_cnt <= 0) begin
        bus.mul_done = 1'b1;
        bus.mul_prod = mdl_prod;
        mdl_pend     = 1'b0;
      end
    end
    if (bus.mul_start) begin
      starts++;
      op_log.push_back({bus.mul_a, bus.mul_b});
      if (starts != drop_at) begin
        p        = clmul({13'b0, bus.mul_a}, {13'b0, bus.mul_b});
        mdl_prod = p[24:0];
        mdl_cnt  = lat_cfg;
        mdl_pend = 1'b1;
      end
    end
  end

  task automatic run_op(
    input  logic [25:0] a,
    input  logic [25:0] b,
    input  int          lat,
    input  int          hold,
    input  bit          chk_lat,
    output logic [50:0] res
  );
    logic [50:0] exp;
    logic [50:0] r0;
    int          s0;
    int          n;
    logic        rdy;
    exp     = clmul(a, b);
    s0      = starts;
    lat_cfg = lat;
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    n = 0;
    do begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    bus.in_valid = 1'b0;
    if (!rdy) chk("accept_timeout", 0, 1);
    n = 0;
    while (!bus.out_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid", bus.out_valid, 1);
    if (chk_lat) chk("latency", n, 6);
    chk("result", bus.result, exp);
    r0 = bus.result;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = ~a;
      bus.b_in     = ~b;
      @(posedge clk); #1;
      chk("hold_result", bus.result, r0);
      chk("hold_ov", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    chk("start_pulses", starts - s0, 3);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("ov_clear", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    res = r0;
  endtask

  initial begin
    logic [50:0] res;
    logic [25:0] ra;
    logic [25:0] rb;
    logic [25:0] e0;
    logic [25:0] e1;
    logic [25:0] e2;
    logic        seen_ov;
    logic        seen_busy;
    int          s0;
    int          n;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 2: small operands, operand sequence and latency
    s0 = starts;
    run_op(26'h3, 26'h3, 1, 0, 1'b1, res);
    chk("t2_result", res, 51'h5);
    e0 = {13'd3, 13'd3};
    e1 = {13'd3, 13'd3};
    e2 = {13'd0, 13'd0};
    chk("t2_op0", op_log[s0], e0);
    chk("t2_op1", op_log[s0+1], e1);
    chk("t2_op2", op_log[s0+2], e2);

    // Test 3
    s0 = starts;
    run_op(26'h2001, 26'h0003, 1, 0, 1'b1, res);
    chk("t3_result", res, 51'h6003);
    e0 = {13'd1, 13'd3};
    e1 = {13'd0, 13'd3};
    e2 = {13'd1, 13'd0};
    chk("t3_op0", op_log[s0], e0);
    chk("t3_op1", op_log[s0+1], e1);
    chk("t3_op2", op_log[s0+2], e2);

    // Test 4: consumer stall with operands offered
    run_op(26'h2000, 26'h2000, 1, 5, 1'b1, res);
    chk("t4_result", res, 51'h4000000);

    // Test 1: asynchronous reset mid-WAIT at k=1
    lat_cfg = 10;
    s0 = starts;
    bus.in_valid = 1'b1;
    bus.a_in     = 26'h155aa33;
    bus.b_in     = 26'h0f0f0f1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (starts < s0 + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t1_reach_k1", starts - s0, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_busy_pre", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_in_ready", bus.in_ready, 1);
    chk("t1_busy", bus.busy, 0);
    chk("t1_mul_start", bus.mul_start, 0);
    chk("t1_mul_a", bus.mul_a, 0);
    chk("t1_mul_b", bus.mul_b, 0);
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_result", bus.result, 0);
    chk("t1_err", bus.err, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    seen_ov   = 1'b0;
    seen_busy = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen_ov   = seen_ov | bus.out_valid;
      seen_busy = seen_busy | bus.busy;
    end
    chk("t1_no_ov", seen_ov, 0);
    chk("t1_no_busy", seen_busy, 0);

    // Test 6: multiplier silent at k=2 -> timeout
    lat_cfg = 2;
    s0      = starts;
    drop_at = starts + 3;
    bus.in_valid = 1'b1;
    bus.a_in     = 26'h3ffffff;
    bus.b_in     = 26'h1234567;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!(bus.mul_start && starts == s0 + 2) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_third_issue", bus.mul_start, 1);
    seen_ov = 1'b0;
    repeat (64) begin
      @(posedge clk); #1;
      seen_ov = seen_ov | bus.out_valid;
    end
    chk("t6_err_early", bus.err, 0);
    chk("t6_busy_early", bus.busy, 1);
    @(posedge clk); #1;
    seen_ov = seen_ov | bus.out_valid;
    chk("t6_err", bus.err, 1);
    chk("t6_idle", bus.busy, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_no_ov", seen_ov, 0);
    drop_at = -1;
    run_op(26'h3ffffff, 26'h1234567, 1, 0, 1'b1, res);
    chk("t6_err_cleared", bus.err, 0);

    // Test 5: random operands, random multiplier latency
    for (int i = 0; i < 1000; i++) begin
      ra = 26'($urandom);
      rb = 26'($urandom);
      run_op(ra, rb, int'($urandom_range(1, 10)), 0, 1'b0, res);
    end
    chk("t5_err", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
